// File: rtl/digit_entry_sequencer.sv
// Control FSM for the board digit-entry datapath: key edge detection, digit
// counter, clear/commit writes into an external 16x4 RAM, and scrolling playback.
module digit_entry_sequencer #(
  parameter int DEPTH        = 7,
  parameter int NUM_MAX      = 9,
  parameter int SCROLL_TICKS = 5_000_000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        key_inc_n,
  input  logic        key_next_n,
  input  logic        play,
  output logic        mem_we,
  output logic [3:0]  mem_addr,
  output logic [3:0]  mem_wdata,
  input  logic [3:0]  mem_rdata,
  output logic [3:0]  num,
  output logic [3:0]  addr,
  output logic [23:0] disp,
  output logic        busy
);

  typedef enum logic [1:0] {S_CLEAR, S_ENTRY, S_COMMIT, S_PLAY} state_e;

  localparam int              SW          = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
  localparam logic [3:0]      LAST_POS    = 4'(DEPTH - 1);
  localparam logic [3:0]      NUM_TOP     = 4'(NUM_MAX);
  localparam logic [SW-1:0]   SCROLL_LAST = SW'(SCROLL_TICKS - 1);

  state_e        state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [3:0]    num_q, num_d;
  logic [3:0]    clr_ptr_q, clr_ptr_d;
  logic [3:0]    rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] scroll_q, scroll_d;
  logic [23:0]   disp_q, disp_d;
  // [0]=s1, [1]=s2, [2]=s3 history
  logic [2:0]    inc_sync_q, inc_sync_d;
  logic [2:0]    next_sync_q, next_sync_d;
  logic          inc_press, next_press;

  assign inc_press  = inc_sync_q[2]  & ~inc_sync_q[1];
  assign next_press = next_sync_q[2] & ~next_sync_q[1];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    num_d       = num_q;
    clr_ptr_d   = clr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    scroll_d    = scroll_q;
    disp_d      = disp_q;
    inc_sync_d  = {inc_sync_q[1:0], key_inc_n};
    next_sync_d = {next_sync_q[1:0], key_next_n};

    case (state_q)
      S_CLEAR: begin
        if (clr_ptr_q == LAST_POS) begin
          clr_ptr_d = 4'd0;
          state_d   = S_ENTRY;
        end else begin
          clr_ptr_d = clr_ptr_q + 4'd1;
        end
      end
      S_ENTRY: begin
        if (next_press) begin
          state_d = S_COMMIT;
        end else if (play) begin
          state_d  = S_PLAY;
          rd_ptr_d = 4'd0;
          scroll_d = '0;
        end else if (inc_press) begin
          num_d = (num_q == NUM_TOP) ? 4'd0 : num_q + 4'd1;
        end
      end
      S_COMMIT: begin
        addr_d  = (addr_q == LAST_POS) ? 4'd0 : addr_q + 4'd1;
        num_d   = 4'd0;
        state_d = S_ENTRY;
      end
      default: begin
        if (!play) begin
          state_d = S_ENTRY;
        end else if (scroll_q == SCROLL_LAST) begin
          scroll_d = '0;
          disp_d   = {disp_q[19:0], mem_rdata};
          rd_ptr_d = (rd_ptr_q == LAST_POS) ? 4'd0 : rd_ptr_q + 4'd1;
        end else begin
          scroll_d = scroll_q + SW'(1);
        end
      end
    endcase

    if (state_d == S_ENTRY)
      disp_d = {16'hFFFF, addr_d, num_d};
    else if (state_q == S_ENTRY && state_d == S_PLAY)
      disp_d = 24'hFFFFFF;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q     <= S_CLEAR;
      addr_q      <= 4'd0;
      num_q       <= 4'd0;
      clr_ptr_q   <= 4'd0;
      rd_ptr_q    <= 4'd0;
      scroll_q    <= '0;
      disp_q      <= 24'hFFFFFF;
      inc_sync_q  <= 3'b111;
      next_sync_q <= 3'b111;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      num_q       <= num_d;
      clr_ptr_q   <= clr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      scroll_q    <= scroll_d;
      disp_q      <= disp_d;
      inc_sync_q  <= inc_sync_d;
      next_sync_q <= next_sync_d;
    end
  end

  // Gating with resetn keeps a reset landing mid-COMMIT from writing the RAM.
  always_comb begin
    mem_we    = resetn && (state_q == S_CLEAR || state_q == S_COMMIT);
    mem_wdata = (state_q == S_COMMIT) ? num_q : 4'd0;
    case (state_q)
      S_CLEAR: mem_addr = clr_ptr_q;
      S_PLAY:  mem_addr = rd_ptr_q;
      default: mem_addr = addr_q;
    endcase
  end

  assign busy = (state_q == S_CLEAR) || (state_q == S_COMMIT);
  assign num  = num_q;
  assign addr = addr_q;
  assign disp = disp_q;

endmodule

// File: tb/tb_digit_entry_sequencer.sv
// Bench for digit_entry_sequencer: table of key operations with expected
// counter/position/display, plus a write scoreboard against a RAM model.
module tb_digit_entry_sequencer;

  localparam int DEPTH = 7;
  localparam int TICKS = 4;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b0, key_inc_n = 1'b1, key_next_n = 1'b1, play = 1'b0;
  logic        mem_we, busy;
  logic [3:0]  mem_addr, mem_wdata, num, addr;
  logic [3:0]  mem_rdata = 4'd0;
  logic [23:0] disp;

  digit_entry_sequencer #(.DEPTH(DEPTH), .NUM_MAX(9), .SCROLL_TICKS(TICKS)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .key_inc_n(key_inc_n), .key_next_n(key_next_n),
    .play(play), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .num(num), .addr(addr), .disp(disp), .busy(busy));

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [3:0] ram [16];
  always @(posedge CLOCK_50) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int total = 0, bad = 0;

  typedef struct packed {logic [3:0] a; logic [3:0] d;} wr_t;
  wr_t exp_wr[$];
  wr_t mon_w;

  typedef struct {int op; logic [3:0] n; logic [3:0] a;} vec_t;
  vec_t vecs[$];

  logic [3:0]  e_num, e_addr;
  logic [23:0] e_disp;
  int          digits[7] = '{2, 4, 0, 5, 2, 0, 2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Every RAM write cycle must match the next expected write in order.
  always @(negedge CLOCK_50) begin
    if (mem_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h want no write", mem_addr, mem_wdata);
      end else begin
        mon_w = exp_wr.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_w.a));
        chk("wr_data", 32'(mem_wdata), 32'(mon_w.d));
      end
    end
  end

  task automatic step();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic do_reset(input int edges);
    int n;
    resetn = 1'b0;
    repeat (edges) step();
    chk("rst_disp", 32'(disp), 32'h00FFFFFF);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_num", 32'(num), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    for (int i = 0; i < DEPTH; i++) exp_wr.push_back({4'(i), 4'd0});
    resetn = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      n++;
      step();
    end
    chk("clear_busy_cycles", 32'(n), 32'(DEPTH));
    chk("entry_addr", 32'(addr), 32'd0);
    chk("entry_num", 32'(num), 32'd0);
    chk("entry_disp", 32'(disp), 32'h00FFFF00);
    e_num = 4'd0;
    e_addr = 4'd0;
  endtask

  // op: 0 inc, 1 next, 2 inc+next together, 3 inc held for 100 cycles
  task automatic apply(input int op, input logic [3:0] en, input logic [3:0] ea);
    if (op == 1 || op == 2) exp_wr.push_back({e_addr, e_num});
    if (op != 1) key_inc_n = 1'b0;
    if (op == 1 || op == 2) key_next_n = 1'b0;
    repeat ((op == 3) ? 100 : 1) step();
    key_inc_n = 1'b1;
    key_next_n = 1'b1;
    repeat (5) step();
    chk("op_num", 32'(num), 32'(en));
    chk("op_addr", 32'(addr), 32'(ea));
    chk("op_disp", 32'(disp), {8'h00, 16'hFFFF, ea, en});
    e_num = en;
    e_addr = ea;
  endtask

  initial begin
    vecs.push_back('{1, 4'd0, 4'd1});
    for (int i = 1; i <= 11; i++) vecs.push_back('{0, 4'(i % 10), 4'd1});
    vecs.push_back('{1, 4'd0, 4'd2});
    for (int i = 1; i <= 3; i++) vecs.push_back('{0, 4'(i), 4'd2});
    vecs.push_back('{2, 4'd0, 4'd3});
    vecs.push_back('{3, 4'd1, 4'd3});
    vecs.push_back('{1, 4'd0, 4'd4});
    vecs.push_back('{1, 4'd0, 4'd5});
    vecs.push_back('{1, 4'd0, 4'd6});
    vecs.push_back('{1, 4'd0, 4'd0});

    do_reset(2);

    // First press, then exact latency of the second press
    apply(0, 4'd1, 4'd0);
    key_inc_n = 1'b0;
    step();
    key_inc_n = 1'b1;
    step();
    chk("num_before_action", 32'(num), 32'd1);
    step();
    chk("num_at_action", 32'(num), 32'd2);
    repeat (3) step();
    e_num = 4'd2;

    foreach (vecs[i]) apply(vecs[i].op, vecs[i].n, vecs[i].a);

    // Reset landing while in COMMIT: no write, CLEAR restarts at 0
    apply(0, 4'd1, 4'd0);
    key_next_n = 1'b0;
    step();
    key_next_n = 1'b1;
    step();
    step();
    chk("in_commit_busy", 32'(busy), 32'd1);
    do_reset(1);

    // Load 2,4,0,5,2,0,2 through normal entry
    for (int j = 0; j < DEPTH; j++) begin
      for (int k = 1; k <= digits[j]; k++) apply(0, 4'(k), 4'(j));
      apply(1, 4'd0, 4'((j + 1) % DEPTH));
    end
    apply(0, 4'd1, 4'd0);

    play = 1'b1;
    step();
    e_disp = 24'hFFFFFF;
    chk("play_blank", 32'(disp), 32'(e_disp));
    for (int c = 1; c <= 32; c++) begin
      if (c == 10) key_inc_n = 1'b0;
      if (c == 12) key_inc_n = 1'b1;
      step();
      if (c % 4 == 0) e_disp = {e_disp[19:0], 4'(digits[(c / 4 - 1) % DEPTH])};
      chk("play_disp", 32'(disp), 32'(e_disp));
    end
    chk("play_final_disp", 32'(disp), 32'h00052022);
    play = 1'b0;
    step();
    chk("exit_disp", 32'(disp), 32'h00FFFF01);
    chk("exit_addr", 32'(addr), 32'd0);
    chk("exit_num", 32'(num), 32'd1);
    chk("exit_busy", 32'(busy), 32'd0);
    repeat (3) step();
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_entry_sequencer.md
Name: digit_entry_sequencer

Overview:
- Control FSM for the board digit-entry datapath.
- Turns raw KEY presses into increment and advance events.
- Owns the position address and the digit counter, and sequences writes of entered digits into an external synchronous 16x4 digit RAM.
- Provides a playback mode that scrolls stored digits across the six HEX nibbles; seven-segment decoding is done downstream.

Parameters:
- DEPTH, 7: number of digit positions used (1..16).
- NUM_MAX, 9: largest digit value; the counter wraps to 0 after it.
- SCROLL_TICKS, 5_000_000: clock cycles per scroll step (0.1 s at 50 MHz); benches use 4.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous active-low reset.
- key_inc_n  in  1  raw active-low increment key (KEY[1]).
- key_next_n  in  1  raw active-low advance key (KEY[0]).
- play  in  1  level; high requests playback.
- mem_we  out  1  RAM write enable.
- mem_addr  out  4  RAM address.
- mem_wdata  out  4  RAM write data.
- mem_rdata  in  4  RAM read data; 1-cycle synchronous read latency.
- num  out  4  current digit being entered.
- addr  out  4  current entry position.
- disp  out  24  six nibbles, disp[3:0]=HEX0 … disp[23:20]=HEX5; 4'hF = blank.
- busy  out  1  high in CLEAR and COMMIT.

Behaviour:
- Reset: one clock; resetn is synchronous and active-low.
  - resetn low at a rising edge, in any state, forces: state=CLEAR, addr=0, num=0, clr_ptr=0, mem_we=0, disp=24'hFFFFFF, scroll counter=0, key sync flops=1.
  - Reset mid-COMMIT aborts the write; CLEAR overwrites the RAM anyway.
- Key front end (per key):
  - Two-flop synchroniser s1→s2, plus history flop s3.
  - press = s3 & ~s2, one cycle wide; no debounce.
  - Key pin low before edge k → press high in the cycle after edge k+1 → action takes effect at edge k+2.
  - A held key produces exactly one press.
- CLEAR:
  - mem_we=1, mem_wdata=0, mem_addr=clr_ptr.
  - clr_ptr increments each cycle; after writing DEPTH-1, next state is ENTRY.
  - Exactly DEPTH write cycles; presses during CLEAR are discarded.
- ENTRY:
  - mem_we=0, mem_addr=addr.
  - inc press: num ← (num==NUM_MAX) ? 0 : num+1.
  - next press: go to COMMIT.
  - inc and next in the same cycle: next wins, inc is dropped.
  - play=1 (and no next press): go to PLAY with rd_ptr=0, scroll counter=0, disp=all blank.
  - disp = {16'hFFFF, addr, num}.
- COMMIT (exactly 1 cycle):
  - mem_we=1, mem_addr=addr, mem_wdata=num.
  - Next edge: addr ← (addr==DEPTH-1) ? 0 : addr+1, num ← 0, go to ENTRY.
- PLAY:
  - mem_addr=rd_ptr; keys ignored; num and addr held.
  - The scroll counter counts 0..SCROLL_TICKS-1.
  - On the wrap edge: disp ← {disp[19:0], mem_rdata} and rd_ptr ← (rd_ptr==DEPTH-1) ? 0 : rd_ptr+1.
  - rd_ptr is stable ≥1 cycle before the wrap, so mem_rdata is valid.
  - play=0: go to ENTRY next edge; disp reverts to the ENTRY format; addr and num unchanged.
- Arithmetic: all pointers are 4-bit with explicit compare-and-wrap, never modulo-16 overflow. DEPTH=16 is legal.
- num, addr and disp are registered outputs; mem_* are combinational from state and registers.

Test Plan:
- Reset (DEPTH=7) → busy=1 for exactly 7 cycles; writes of 0 to addresses 0..6 in order; then ENTRY with addr=0, num=0, disp=24'hFFFF00.
- 2 inc presses, then 1 next → num=2 two edges after the second press; one cycle with mem_we=1, mem_addr=0, mem_wdata=2; then addr=1, num=0.
- 11 inc presses at addr 1 → num sequence 1..9, 0, 1; commit writes 1 to address 1.
- inc and next pressed in the same cycle with num=3 → write of 3 (not 4); key held low for 100 cycles → single press only.
- Commits at addr 6 → addr wraps to 0; reset asserted in COMMIT → no write at that address, CLEAR restarts from 0.
- RAM preloaded 2,4,0,5,2,0,2; play=1 with SCROLL_TICKS=4 → disp nibble 0 takes 2,4,0,5,2,0,2,2 every 4 cycles with earlier digits shifting left; play=0 → ENTRY display restored, addr unchanged.
